// File: rtl/iot_sensor_pkg.sv
// Purpose: shared types and constants for the sensor subsystem I2C arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: arbiter FSM state enum, default arbiter sizing, requester index map.
package iot_sensor_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ISSUE   = 2'd1,
    ARB_WAIT    = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_e;

  localparam int I2C_ARB_NUM_REQ = 3;
  localparam int I2C_ARB_XFERS   = 2;
  // 1 ms at 100 MHz
  localparam int I2C_ARB_TIMEOUT = 100000;

  // Requester slots on the arbiter
  localparam int REQ_TEMP = 0;
  localparam int REQ_HUM  = 1;
  localparam int REQ_PRES = 2;

endpackage

// File: rtl/rr_priority_picker.sv
// Purpose: round-robin pick of the first set pending bit at or after ptr (wrapping).
// Latency: purely combinational.
// Backpressure: none; the caller decides when to consume the winner.
// Ports: pending (request vector), ptr (search start index),
//        winner (one-hot), winner_idx (binary), valid (any pending).
module rr_priority_picker #(
  parameter int NUM_REQ = 3,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [PW-1:0]      winner_idx,
  output logic               valid
);

  logic [PW-1:0] idx;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    idx        = '0;
    // Walk NUM_REQ slots starting at ptr; the first hit wins.
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PW'((int'(ptr) + k) % NUM_REQ);
      if (!valid && pending[idx]) begin
        winner[idx] = 1'b1;
        winner_idx  = idx;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Purpose: shares one I2C master among NUM_REQ sensor interfaces, round-robin, XFERS_PER_GRANT bytes per grant.
// Latency: req_start in cycle 0 (arbiter idle) -> grant and m_start in cycle 2; next byte starts 1 cycle after m_done.
// Backpressure: requests are latched as pending and held until granted; hung transfers are aborted by a watchdog.
// Ports: req_* (per-requester start pulse, packed addr/dir/wdata), rsp_* (read data passthrough,
//        done/ack_error routed to the owner), grant/busy/timeout_err status, m_* (I2C master side).
module i2c_bus_arbiter
  import iot_sensor_pkg::*;
#(
  parameter int NUM_REQ         = I2C_ARB_NUM_REQ,
  parameter int XFERS_PER_GRANT = I2C_ARB_XFERS,
  parameter int TIMEOUT_CYCLES  = I2C_ARB_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_start,
  input  logic [NUM_REQ*7-1:0]   req_slave_addr,
  input  logic [NUM_REQ-1:0]     req_read_write_n,
  input  logic [NUM_REQ*8-1:0]   req_write_data,
  output logic [7:0]             rsp_read_data,
  output logic [NUM_REQ-1:0]     rsp_done,
  output logic [NUM_REQ-1:0]     rsp_ack_error,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   timeout_err,
  output logic                   m_start,
  output logic [6:0]             m_slave_addr,
  output logic                   m_read_write_n,
  output logic [7:0]             m_write_data,
  input  logic [7:0]             m_read_data,
  input  logic                   m_done,
  input  logic                   m_ack_error
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int XW = $clog2(XFERS_PER_GRANT + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES);

  arb_state_e           state;
  logic [NUM_REQ-1:0]   pending;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        owner;
  logic [XW-1:0]        xfer_cnt;
  logic [WW-1:0]        watchdog;

  logic [NUM_REQ-1:0]   pick_onehot;
  logic [PW-1:0]        pick_idx;
  logic                 pick_valid;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_picker (
    .pending    (pending),
    .ptr        (rr_ptr),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .valid      (pick_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ARB_IDLE;
      pending        <= '0;
      rr_ptr         <= '0;
      owner          <= '0;
      xfer_cnt       <= '0;
      watchdog       <= '0;
      grant          <= '0;
      timeout_err    <= 1'b0;
      m_start        <= 1'b0;
      m_slave_addr   <= '0;
      m_read_write_n <= 1'b1;
      m_write_data   <= '0;
    end else begin
      m_start     <= 1'b0;
      timeout_err <= 1'b0;
      // New pulses always land in pending, including from the current owner,
      // so a re-request is queued behind everyone else already waiting.
      pending     <= pending | req_start;

      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            grant          <= pick_onehot;
            owner          <= pick_idx;
            m_slave_addr   <= req_slave_addr[int'(pick_idx)*7 +: 7];
            m_read_write_n <= req_read_write_n[pick_idx];
            m_write_data   <= req_write_data[int'(pick_idx)*8 +: 8];
            pending        <= (pending & ~pick_onehot) | req_start;
            xfer_cnt       <= '0;
            m_start        <= 1'b1;
            state          <= ARB_ISSUE;
          end
        end

        ARB_ISSUE: begin
          watchdog <= '0;
          state    <= ARB_WAIT;
        end

        ARB_WAIT: begin
          if (m_ack_error) begin
            state <= ARB_RELEASE;
          end else if (m_done) begin
            if (xfer_cnt < XW'(XFERS_PER_GRANT - 1)) begin
              xfer_cnt <= xfer_cnt + 1'b1;
              m_start  <= 1'b1;
              state    <= ARB_ISSUE;
            end else begin
              state <= ARB_RELEASE;
            end
          end else if (watchdog == WW'(TIMEOUT_CYCLES - 1)) begin
            // Grant is still held during RELEASE, so the pulse reaches the owner.
            timeout_err <= 1'b1;
            state       <= ARB_RELEASE;
          end else if (watchdog != '1) begin
            watchdog <= watchdog + 1'b1;
          end
        end

        ARB_RELEASE: begin
          grant  <= '0;
          rr_ptr <= (owner == PW'(NUM_REQ - 1)) ? '0 : owner + PW'(1);
          state  <= ARB_IDLE;
        end

        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign busy          = (state != ARB_IDLE);
  assign rsp_read_data = m_read_data;
  assign rsp_done      = {NUM_REQ{m_done}} & grant;
  assign rsp_ack_error = ({NUM_REQ{m_ack_error}} & grant) | ({NUM_REQ{timeout_err}} & grant);

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Purpose: directed self-checking bench for i2c_bus_arbiter with a response scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_i2c_bus_arbiter;

  localparam int N = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_start = '0;
  logic [N*7-1:0]  req_slave_addr;
  logic [N-1:0]    req_read_write_n;
  logic [N*8-1:0]  req_write_data;
  logic [7:0]      rsp_read_data;
  logic [N-1:0]    rsp_done;
  logic [N-1:0]    rsp_ack_error;
  logic [N-1:0]    grant;
  logic            busy;
  logic            timeout_err;
  logic            m_start;
  logic [6:0]      m_slave_addr;
  logic            m_read_write_n;
  logic [7:0]      m_write_data;
  logic [7:0]      m_read_data = '0;
  logic            m_done = 1'b0;
  logic            m_ack_error = 1'b0;

  logic [6:0] addr_tbl [N] = '{7'h48, 7'h40, 7'h77};
  logic       rw_tbl   [N] = '{1'b1, 1'b1, 1'b0};
  logic [7:0] wd_tbl   [N] = '{8'hA0, 8'hA1, 8'hA2};

  typedef struct {
    logic [N-1:0] who;
    logic [7:0]   data;
    bit           err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  i2c_bus_arbiter #(
    .NUM_REQ         (N),
    .XFERS_PER_GRANT (2),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_start        (req_start),
    .req_slave_addr   (req_slave_addr),
    .req_read_write_n (req_read_write_n),
    .req_write_data   (req_write_data),
    .rsp_read_data    (rsp_read_data),
    .rsp_done         (rsp_done),
    .rsp_ack_error    (rsp_ack_error),
    .grant            (grant),
    .busy             (busy),
    .timeout_err      (timeout_err),
    .m_start          (m_start),
    .m_slave_addr     (m_slave_addr),
    .m_read_write_n   (m_read_write_n),
    .m_write_data     (m_write_data),
    .m_read_data      (m_read_data),
    .m_done           (m_done),
    .m_ack_error      (m_ack_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_start = '0;
    m_done = 1'b0;
    m_ack_error = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse(input logic [N-1:0] mask);
    req_start = mask;
    tick();
    req_start = '0;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (m_start !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check("m_start_seen", m_start, 1'b1);
  endtask

  // One byte transaction: expects a start for requester idx, optionally pulses
  // req_start during the ISSUE cycle, then answers with done or ack_error.
  task automatic serve_byte(input int idx, input logic [7:0] data, input bit err,
                            input logic [N-1:0] pre, output int waited);
    logic [N-1:0] oh;
    oh = N'(1) << idx;
    wait_start(waited);
    check("grant_owner", grant, oh);
    check("m_slave_addr", m_slave_addr, addr_tbl[idx]);
    check("m_read_write_n", m_read_write_n, rw_tbl[idx]);
    check("m_write_data", m_write_data, wd_tbl[idx]);
    req_start = pre;
    tick();
    req_start = '0;
    check("m_start_one_cycle", m_start, 1'b0);
    tick();
    sb.push_back('{oh, data, err});
    m_read_data = data;
    if (err) m_ack_error = 1'b1;
    else     m_done = 1'b1;
    tick();
    m_done = 1'b0;
    m_ack_error = 1'b0;
  endtask

  task automatic serve_burst(input int idx, input logic [7:0] d0, input logic [7:0] d1,
                             input logic [N-1:0] pre);
    int w;
    serve_byte(idx, d0, 1'b0, pre, w);
    serve_byte(idx, d1, 1'b0, '0, w);
    check("b2b_start_latency", w, 0);
    tick();
    check("grant_released", grant, '0);
    check("busy_idle", busy, 1'b0);
  endtask

  // Scoreboard consumer: every done/ack_error seen must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && ((|rsp_done) || (|rsp_ack_error))) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_rsp", {rsp_done, rsp_ack_error}, '0);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.err) begin
          check("rsp_ack_error", rsp_ack_error, mon_e.who);
          check("rsp_done_on_err", rsp_done, '0);
        end else begin
          check("rsp_done", rsp_done, mon_e.who);
          check("rsp_read_data", rsp_read_data, mon_e.data);
          check("rsp_ack_error_on_done", rsp_ack_error, '0);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_guard observed=timeout expected=finish");
    $fatal(1, "simulation guard expired");
  end

  initial begin
    int w;
    req_slave_addr   = {addr_tbl[2], addr_tbl[1], addr_tbl[0]};
    req_read_write_n = {rw_tbl[2], rw_tbl[1], rw_tbl[0]};
    req_write_data   = {wd_tbl[2], wd_tbl[1], wd_tbl[0]};

    // Reset state
    do_reset();
    check("rst_grant", grant, '0);
    check("rst_m_start", m_start, 1'b0);
    check("rst_m_slave_addr", m_slave_addr, 7'h00);
    check("rst_m_read_write_n", m_read_write_n, 1'b1);
    check("rst_m_write_data", m_write_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);

    // Single requester 1, two reads 0x12/0x34, start latency of 2 cycles
    pulse(3'b010);
    check("lat_cycle1_grant", grant, '0);
    check("lat_cycle1_m_start", m_start, 1'b0);
    tick();
    check("lat_cycle2_grant", grant, 3'b010);
    check("lat_cycle2_m_start", m_start, 1'b1);
    check("lat_cycle2_busy", busy, 1'b1);
    serve_burst(1, 8'h12, 8'h34, '0);

    // All three at once from pointer 0, then a second round
    do_reset();
    pulse(3'b111);
    serve_burst(0, 8'h01, 8'h02, '0);
    serve_burst(1, 8'h11, 8'h12, '0);
    serve_burst(2, 8'h21, 8'h22, '0);
    pulse(3'b111);
    serve_burst(0, 8'h31, 8'h32, '0);
    serve_burst(1, 8'h41, 8'h42, '0);
    serve_burst(2, 8'h51, 8'h52, '0);

    // NACK on first byte of requester 2 while requester 0 is pending
    do_reset();
    pulse(3'b100);
    serve_byte(2, 8'h55, 1'b1, 3'b001, w);
    check("nack_release_m_start", m_start, 1'b0);
    check("nack_release_grant", grant, 3'b100);
    tick();
    check("nack_idle_grant", grant, '0);
    serve_burst(0, 8'h66, 8'h77, '0);

    // Master never answers: watchdog expiry after 16 WAIT cycles
    do_reset();
    pulse(3'b010);
    wait_start(w);
    repeat (16) tick();
    check("wd_not_yet", timeout_err, 1'b0);
    check("wd_busy", busy, 1'b1);
    sb.push_back('{3'b010, 8'h00, 1'b1});
    tick();
    check("wd_timeout_err", timeout_err, 1'b1);
    tick();
    check("wd_pulse_width", timeout_err, 1'b0);
    check("wd_grant_after", grant, '0);
    check("wd_busy_after", busy, 1'b0);

    // Owner re-requests during its burst while requester 0 also waits
    do_reset();
    pulse(3'b010);
    serve_burst(1, 8'h81, 8'h82, 3'b011);
    serve_burst(0, 8'h91, 8'h92, '0);
    serve_burst(1, 8'hA1, 8'hA2, '0);

    // Reset in the middle of a burst drops everything, including pending work
    do_reset();
    pulse(3'b100);
    wait_start(w);
    req_start = 3'b001;
    tick();
    req_start = '0;
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_grant", grant, '0);
    check("midrst_m_start", m_start, 1'b0);
    check("midrst_busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("midrst_no_grant", grant, '0);
    check("midrst_still_idle", busy, 1'b0);
    pulse(3'b001);
    serve_burst(0, 8'hC1, 8'hC2, '0);

    repeat (3) tick();
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares the single I2C master between the I2C sensor interfaces (humidity, temperature, pressure…).
- Each requester issues a one-cycle start request with address/direction/data. The arbiter grants round-robin and sequences XFERS_PER_GRANT byte transactions on the master per grant.
- Routes done/ack_error back to the granted requester only, and aborts hung transfers with a watchdog.
- Sits between the sensor interfaces and the I2C master in the sensor subsystem.

Parameters:
NUM_REQ, 3, number of requesting sensor interfaces (2..8)
XFERS_PER_GRANT, 2, byte transactions issued per grant (MSB+LSB read)
TIMEOUT_CYCLES, 100000, max cycles waiting for m_done/m_ack_error (1 ms @ 100 MHz)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_start  in  NUM_REQ  per-requester start pulse
req_slave_addr  in  NUM_REQ*7  packed 7-bit addresses, requester i at [7i+6:7i]
req_read_write_n  in  NUM_REQ  1=read
req_write_data  in  NUM_REQ*8  packed write bytes
rsp_read_data  out  8  m_read_data passthrough (all requesters)
rsp_done  out  NUM_REQ  m_done gated by grant
rsp_ack_error  out  NUM_REQ  error/timeout to granted requester
grant  out  NUM_REQ  one-hot current owner, 0 when idle
busy  out  1  state != ARB_IDLE
timeout_err  out  1  one-cycle pulse on watchdog expiry
m_start  out  1  one-cycle start to I2C master
m_slave_addr  out  7  latched address of owner
m_read_write_n  out  1  latched direction
m_write_data  out  8  latched write byte
m_read_data  in  8  master read byte
m_done  in  1  master transaction complete
m_ack_error  in  1  master NACK

Behaviour:
- Reset: grant=0, m_start=0, m_slave_addr=0, m_read_write_n=1, m_write_data=0, timeout_err=0, busy=0, pending=0, rr pointer=0, state ARB_IDLE.
- pending[i] set on req_start[i]. Cleared when requester i is granted. A pulse while already pending is absorbed. A pulse from the current owner during its burst sets pending, so it is queued for a later grant.
- States:
  - ARB_IDLE: if pending!=0, pick the first pending index at or after rr pointer (wrapping). Register grant, latch its addr/rw/wdata, clear its pending bit, xfer_cnt=0 -> ARB_ISSUE.
  - ARB_ISSUE: m_start=1 for exactly this cycle; watchdog=0 -> ARB_WAIT.
  - ARB_WAIT: watchdog increments each cycle.
    - m_ack_error (priority over m_done) -> ARB_RELEASE.
    - m_done with xfer_cnt<XFERS_PER_GRANT-1 -> xfer_cnt++, ARB_ISSUE.
    - m_done on last transaction -> ARB_RELEASE.
    - watchdog==TIMEOUT_CYCLES-1 -> timeout_err pulse, rsp_ack_error[owner] pulse -> ARB_RELEASE.
  - ARB_RELEASE: grant=0, rr pointer=(owner+1) mod NUM_REQ -> ARB_IDLE.
- Combinational outputs:
  - rsp_done = {NUM_REQ{m_done}} & grant
  - rsp_ack_error = ({NUM_REQ{m_ack_error}} & grant) | timeout pulse
  - rsp_read_data = m_read_data
- Latency: req_start in cycle 0 with the arbiter idle -> grant and m_start in cycle 2. Back-to-back transactions in a burst start 1 cycle after m_done.
- m_done/m_ack_error outside ARB_WAIT are ignored.
- Widths: xfer_cnt is $clog2(XFERS_PER_GRANT+1) bits; watchdog is $clog2(TIMEOUT_CYCLES) bits and saturates.
- Reset mid-burst: everything returns to reset values immediately and pending requests are lost.

Decomposition:
- iot_sensor_pkg gets:
  - arb_state_e (ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RELEASE)
  - I2C_ARB_NUM_REQ
  - I2C_ARB_TIMEOUT
  - requester index constants (REQ_TEMP=0, REQ_HUM=1, REQ_PRES=2)
- One sub-module, rr_priority_picker: combinational; takes pending and pointer, returns one-hot winner and a valid flag.

Test Plan:
- Single req_start[1], addr 0x40, master returns 0x12 then 0x34 -> m_start two cycles later, two m_start pulses, rsp_done[1] pulses twice with rsp_read_data 0x12/0x34, grant returns to 0.
- req_start[0..2] same cycle, pointer 0 -> grant order 0,1,2. A second round requested immediately after -> order 0,1,2 again.
- m_ack_error on first byte of requester 2 -> rsp_ack_error[2]=1 for one cycle, no second m_start, next pending requester granted.
- Master never responds -> timeout_err and rsp_ack_error[owner] after TIMEOUT_CYCLES (param set to 16 in bench), arbiter idle afterwards.
- Owner re-pulses req_start during its burst while requester 0 is also pending -> requester 0 served before the owner's queued request.
- rst_n asserted in ARB_WAIT -> grant=0, m_start=0, busy=0 immediately. No grant after release until a new req_start.
